// File: rtl/cpri_rx_lane_sched_pkg.sv
// Shared state encoding and parameter defaults for the CPRI rx lane read scheduler.
package cpri_rx_pkg;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_GAP} sched_st_t;

    localparam int unsigned CPRI_SYMB_LEN = 792;
    localparam int unsigned CPRI_TO_CYC   = 4096;

endpackage

// File: rtl/cpri_rx_lane_sched_sat_cnt16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_cnt16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] cnt
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/cpri_rx_lane_sched.sv
// Common read-burst scheduler for the per-lane CPRI rx buffers: waits for every enabled lane,
// reads one aligned symbol from all of them, and flags timeouts and end-of-symbol misalignment.
module cpri_rx_lane_sched
    import cpri_rx_pkg::*;
#(
    parameter int unsigned LANE     = 8,
    parameter int unsigned SYMB_LEN = CPRI_SYMB_LEN,
    parameter int unsigned TO_CYC   = CPRI_TO_CYC,
    parameter int unsigned GAP_CYC  = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [LANE-1:0] i_lane_en,
    input  logic [LANE-1:0] i_rd_vld,
    input  logic [LANE-1:0] i_symb_eop,
    output logic            o_rd_en,
    output logic            o_sop,
    output logic            o_eop,
    output logic            o_busy,
    output logic            o_to_pulse,
    output logic [LANE-1:0] o_to_mask,
    output logic            o_align_err,
    output logic [15:0]     o_symb_cnt,
    output logic [15:0]     o_err_cnt
);

    localparam int unsigned RD_W  = $clog2(SYMB_LEN);
    localparam int unsigned TO_W  = $clog2(TO_CYC + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);

    localparam logic [RD_W-1:0]  RD_LAST  = RD_W'(SYMB_LEN - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    sched_st_t        state_q, state_d;
    logic [RD_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [LANE-1:0]  en_q, en_d;
    logic             err_seen_q, err_seen_d;
    logic             rd_en_q, rd_en_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;
    logic             busy_q, busy_d;
    logic             to_pulse_q, to_pulse_d;
    logic [LANE-1:0]  to_mask_q, to_mask_d;
    logic             align_err_q, align_err_d;
    logic [15:0]      symb_cnt_q, symb_cnt_d;

    logic [LANE-1:0]  act;
    logic             all_rdy;
    logic             start;
    logic             burst_err;
    logic             err_inc;

    always_comb begin
        act         = i_lane_en & i_rd_vld;
        all_rdy     = (act == i_lane_en) && (i_lane_en != '0);
        start       = 1'b0;
        burst_err   = 1'b0;
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        to_cnt_d    = to_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        en_d        = en_q;
        err_seen_d  = err_seen_q;
        to_pulse_d  = 1'b0;
        to_mask_d   = to_mask_q;
        align_err_d = 1'b0;
        symb_cnt_d  = symb_cnt_q;

        case (state_q)
            S_IDLE: begin
                to_cnt_d = '0;
                if (all_rdy) begin
                    start = 1'b1;
                end else if (|act) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                // all_rdy takes priority over a timeout landing in the same cycle
                if (all_rdy) begin
                    start = 1'b1;
                end else if (to_cnt_q == TO_LAST) begin
                    to_mask_d  = i_lane_en & ~i_rd_vld;
                    to_pulse_d = 1'b1;
                    gap_cnt_d  = '0;
                    state_d    = S_GAP;
                end
            end
            S_READ: begin
                if (rd_cnt_q != RD_LAST) begin
                    burst_err = (|(en_q & ~i_rd_vld)) || (|(en_q & i_symb_eop));
                    rd_cnt_d  = rd_cnt_q + RD_W'(1);
                end else begin
                    burst_err  = (i_symb_eop & en_q) != en_q;
                    symb_cnt_d = symb_cnt_q + 16'd1;
                    gap_cnt_d  = '0;
                    state_d    = S_GAP;
                end
                // underrun, early eop and final eop mismatch share one report per burst
                if (burst_err && !err_seen_q) begin
                    align_err_d = 1'b1;
                    err_seen_d  = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (start) begin
            state_d    = S_READ;
            rd_cnt_d   = '0;
            en_d       = i_lane_en;
            err_seen_d = 1'b0;
        end

        // outputs are registered copies of the next-state decode
        rd_en_d = (state_d == S_READ);
        sop_d   = rd_en_d && (rd_cnt_d == '0);
        eop_d   = rd_en_d && (rd_cnt_d == RD_LAST);
        busy_d  = (state_d != S_IDLE);
        err_inc = to_pulse_d | align_err_d;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            rd_cnt_q    <= '0;
            to_cnt_q    <= '0;
            gap_cnt_q   <= '0;
            en_q        <= '0;
            err_seen_q  <= 1'b0;
            rd_en_q     <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            busy_q      <= 1'b0;
            to_pulse_q  <= 1'b0;
            to_mask_q   <= '0;
            align_err_q <= 1'b0;
            symb_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            to_cnt_q    <= to_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            en_q        <= en_d;
            err_seen_q  <= err_seen_d;
            rd_en_q     <= rd_en_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            busy_q      <= busy_d;
            to_pulse_q  <= to_pulse_d;
            to_mask_q   <= to_mask_d;
            align_err_q <= align_err_d;
            symb_cnt_q  <= symb_cnt_d;
        end
    end

    sat_cnt16 u_err_cnt (
        .clk (i_clk),
        .rst (i_reset),
        .inc (err_inc),
        .cnt (o_err_cnt)
    );

    assign o_rd_en     = rd_en_q;
    assign o_sop       = sop_q;
    assign o_eop       = eop_q;
    assign o_busy      = busy_q;
    assign o_to_pulse  = to_pulse_q;
    assign o_to_mask   = to_mask_q;
    assign o_align_err = align_err_q;
    assign o_symb_cnt  = symb_cnt_q;

endmodule

// File: tb/tb_cpri_rx_lane_sched.sv
// Directed bench for cpri_rx_lane_sched: expected burst timing and counter values are queued
// when a scenario is driven and checked in order as the DUT responds.
module tb_cpri_rx_lane_sched;

    localparam int unsigned LANE     = 8;
    localparam int unsigned SYMB_LEN = 792;
    localparam int unsigned TO_CYC   = 64;
    localparam int unsigned GAP_CYC  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [LANE-1:0] lane_en;
    logic [LANE-1:0] rd_vld;
    logic [LANE-1:0] symb_eop;
    logic            rd_en, sop, eop, busy, to_pulse, align_err;
    logic [LANE-1:0] to_mask;
    logic [15:0]     symb_cnt, err_cnt;

    cpri_rx_lane_sched #(
        .LANE     (LANE),
        .SYMB_LEN (SYMB_LEN),
        .TO_CYC   (TO_CYC),
        .GAP_CYC  (GAP_CYC)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_lane_en   (lane_en),
        .i_rd_vld    (rd_vld),
        .i_symb_eop  (symb_eop),
        .o_rd_en     (rd_en),
        .o_sop       (sop),
        .o_eop       (eop),
        .o_busy      (busy),
        .o_to_pulse  (to_pulse),
        .o_to_mask   (to_mask),
        .o_align_err (align_err),
        .o_symb_cnt  (symb_cnt),
        .o_err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endfunction

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        n_vec++;
        assert (sb.size() != 0) else begin
            n_err++;
            $error("FAIL sb_underflow observed=%0h expected=<queued value>", obs);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // act: 0 none, 1 clear lane_en, 2 drop lane 2 rd_vld, 3 assert reset, 4 early eop on lane 0
    task automatic observe_burst(input int max_wait, input int act, input int act_k,
                                 input logic [LANE-1:0] eop_val,
                                 output bit got, output bit rst_hit, output int first_c,
                                 output int sop_c, output int eop_c, output int len,
                                 output int ns, output int ne, output int na);
        int w;
        got = 1'b0; rst_hit = 1'b0; first_c = -1; sop_c = -1; eop_c = -1;
        len = 0; ns = 0; ne = 0; na = 0; w = 0;
        @(negedge clk);
        while (!rd_en && w < max_wait) begin
            @(negedge clk);
            w++;
        end
        got = rd_en;
        if (!got) return;
        first_c = cyc;
        while (rd_en && len < 2 * SYMB_LEN) begin
            if (sop) begin ns++; sop_c = cyc; end
            if (eop) begin ne++; eop_c = cyc; end
            if (align_err) na++;
            symb_eop = (len == SYMB_LEN - 1) ? eop_val : '0;
            if (len == act_k) begin
                case (act)
                    1: lane_en = '0;
                    2: rd_vld[2] = 1'b0;
                    3: begin
                        rst = 1'b1;
                        #1;
                        rst_hit = 1'b1;
                        symb_eop = '0;
                        return;
                    end
                    4: symb_eop[0] = 1'b1;
                    default: ;
                endcase
            end
            len++;
            @(negedge clk);
        end
        symb_eop = '0;
        if (align_err) na++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=time_limit expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got, rst_hit;
        int c0, first_c, sop_c, eop_c, len, ns, ne, na;
        int tp_c, np, nr;

        rst = 1'b1; lane_en = '0; rd_vld = '0; symb_eop = '0;
        settle(3);
        push("rst_rd_en", 0);     pop_chk(rd_en);
        push("rst_busy", 0);      pop_chk(busy);
        push("rst_to_mask", 0);   pop_chk(to_mask);
        push("rst_symb_cnt", 0);  pop_chk(symb_cnt);
        push("rst_err_cnt", 0);   pop_chk(err_cnt);
        push("rst_pulses", 0);    pop_chk({sop, eop, to_pulse, align_err});
        rst = 1'b0;

        // enabled lanes with nothing ready: stays idle
        lane_en = 8'hFF;
        settle(4);
        push("idle_busy", 0);     pop_chk(busy);

        // T1: all lanes ready, then a back-to-back second burst with rd_vld held
        c0 = cyc;
        rd_vld = 8'hFF;
        push("t1_got", 1); push("t1_first", c0 + 1); push("t1_sop", c0 + 1);
        push("t1_eop", c0 + SYMB_LEN); push("t1_len", SYMB_LEN);
        push("t1_nsop", 1); push("t1_neop", 1); push("t1_aerr", 0);
        observe_burst(20, 0, 0, 8'hFF, got, rst_hit, first_c, sop_c, eop_c, len, ns, ne, na);
        pop_chk(got); pop_chk(first_c); pop_chk(sop_c); pop_chk(eop_c); pop_chk(len);
        pop_chk(ns); pop_chk(ne); pop_chk(na);
        push("t1_symb_cnt", 1);   pop_chk(symb_cnt);
        push("t1_gap_busy", 1);   pop_chk(busy);
        push("t1b_first", c0 + SYMB_LEN + GAP_CYC + 2); push("t1b_len", SYMB_LEN);
        observe_burst(20, 0, 0, 8'hFF, got, rst_hit, first_c, sop_c, eop_c, len, ns, ne, na);
        pop_chk(first_c); pop_chk(len);
        rd_vld = '0;
        push("t1b_symb_cnt", 2);  pop_chk(symb_cnt);
        push("t1b_err_cnt", 0);   pop_chk(err_cnt);
        settle(5);

        // T2: lane 7 never ready -> timeout, no read
        c0 = cyc; np = 0; nr = 0; tp_c = -1;
        rd_vld = 8'h7F;
        push("t2_to_cyc", c0 + TO_CYC + 1); push("t2_npulse", 1); push("t2_rd_en_cycles", 0);
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (to_pulse) begin np++; tp_c = cyc; rd_vld = '0; end
            if (rd_en) nr++;
        end
        rd_vld = '0;
        pop_chk(tp_c); pop_chk(np); pop_chk(nr);
        push("t2_to_mask", 8'h80); pop_chk(to_mask);
        push("t2_err_cnt", 1);    pop_chk(err_cnt);
        push("t2_busy", 0);       pop_chk(busy);

        // T2b: last lane arrives exactly on the timeout cycle -> burst wins
        c0 = cyc;
        rd_vld = 8'h7F;
        settle(TO_CYC);
        push("t2b_wait_busy", 1); pop_chk(busy);
        rd_vld = 8'hFF;
        push("t2b_first", c0 + TO_CYC + 1); push("t2b_len", SYMB_LEN);
        observe_burst(20, 0, 0, 8'hFF, got, rst_hit, first_c, sop_c, eop_c, len, ns, ne, na);
        pop_chk(first_c); pop_chk(len);
        rd_vld = '0;
        push("t2b_err_cnt", 1);   pop_chk(err_cnt);
        push("t2b_symb_cnt", 3);  pop_chk(symb_cnt);
        settle(5);

        // T3: only lanes 0-3 enabled; clearing enable mid-burst does not disturb it
        lane_en = 8'h0F;
        settle(2);
        c0 = cyc;
        rd_vld = 8'h0F;
        push("t3_first", c0 + 1); push("t3_len", SYMB_LEN); push("t3_aerr", 0);
        observe_burst(20, 1, 200, 8'h0F, got, rst_hit, first_c, sop_c, eop_c, len, ns, ne, na);
        pop_chk(first_c); pop_chk(len); pop_chk(na);
        push("t3_symb_cnt", 4);   pop_chk(symb_cnt);
        push("t3_err_cnt", 1);    pop_chk(err_cnt);
        push("t3_to_mask_held", 8'h80); pop_chk(to_mask);
        rd_vld = 8'hFF;
        settle(10);
        push("t3_no_lanes_busy", 0); pop_chk(busy);
        rd_vld = '0;
        lane_en = 8'hFF;
        settle(3);

        // T4: lane 3 misses eop on the last word
        rd_vld = 8'hFF;
        push("t4_len", SYMB_LEN); push("t4_aerr", 1);
        observe_burst(20, 0, 0, 8'hF7, got, rst_hit, first_c, sop_c, eop_c, len, ns, ne, na);
        pop_chk(len); pop_chk(na);
        rd_vld = '0;
        push("t4_err_cnt", 2);    pop_chk(err_cnt);
        push("t4_symb_cnt", 5);   pop_chk(symb_cnt);
        settle(5);

        // T4b: premature eop on lane 0
        rd_vld = 8'hFF;
        push("t4b_aerr", 1);
        observe_burst(20, 4, 50, 8'hFF, got, rst_hit, first_c, sop_c, eop_c, len, ns, ne, na);
        pop_chk(na);
        rd_vld = '0;
        push("t4b_err_cnt", 3);   pop_chk(err_cnt);
        settle(5);

        // T5: lane 2 underruns at rd_cnt 100
        rd_vld = 8'hFF;
        push("t5_len", SYMB_LEN); push("t5_aerr", 1);
        observe_burst(20, 2, 100, 8'hFF, got, rst_hit, first_c, sop_c, eop_c, len, ns, ne, na);
        pop_chk(len); pop_chk(na);
        rd_vld = '0;
        push("t5_err_cnt", 4);    pop_chk(err_cnt);
        push("t5_symb_cnt", 7);   pop_chk(symb_cnt);
        settle(5);

        // T5b: underrun plus bad eop in one burst still reports once
        rd_vld = 8'hFF;
        push("t5b_aerr", 1);
        observe_burst(20, 2, 100, 8'hF7, got, rst_hit, first_c, sop_c, eop_c, len, ns, ne, na);
        pop_chk(na);
        rd_vld = '0;
        push("t5b_err_cnt", 5);   pop_chk(err_cnt);
        settle(5);

        // T6: async reset in the middle of a burst
        rd_vld = 8'hFF;
        push("t6_rst_hit", 1);
        observe_burst(20, 3, 300, 8'hFF, got, rst_hit, first_c, sop_c, eop_c, len, ns, ne, na);
        pop_chk(rst_hit);
        push("t6_rd_en_now", 0);  pop_chk(rd_en);
        push("t6_busy_now", 0);   pop_chk(busy);
        push("t6_symb_now", 0);   pop_chk(symb_cnt);
        push("t6_err_now", 0);    pop_chk(err_cnt);
        rd_vld = '0;
        settle(2);
        rst = 1'b0;
        settle(3);
        push("t6_post_busy", 0);  pop_chk(busy);
        push("t6_post_rd_en", 0); pop_chk(rd_en);
        push("t6_post_mask", 0);  pop_chk(to_mask);
        c0 = cyc;
        rd_vld = 8'hFF;
        push("t6_first", c0 + 1); push("t6_len", SYMB_LEN);
        observe_burst(20, 0, 0, 8'hFF, got, rst_hit, first_c, sop_c, eop_c, len, ns, ne, na);
        pop_chk(first_c); pop_chk(len);
        rd_vld = '0;
        push("t6_symb_cnt", 1);   pop_chk(symb_cnt);
        push("t6_err_cnt", 0);    pop_chk(err_cnt);
        settle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
